// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the TX frame arbiter.
package tx_arb_pkg;

   localparam int unsigned LEN_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      PAYLOAD,
      DROP,
      GAP
   } state_t;

   // Width of a source index; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester at or above ptr, with wrap.
module rr_pick
   import tx_arb_pkg::*;
#(
   parameter  int unsigned N_SRC = 2,
   localparam int unsigned IW    = idx_w(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    gnt_idx,
   output logic             any
);

   logic [IW-1:0] idx;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         idx = IW'((32'(ptr) + (N_SRC - 1 - k)) % N_SRC);
         if (req[idx]) begin
            gnt_idx = idx;
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter for length-prefixed byte streams onto one MAC TX port.
module tx_frame_arbiter
   import tx_arb_pkg::*;
#(
   parameter  int unsigned N_SRC      = 2,
   parameter  int unsigned MAX_LEN    = 1500,
   parameter  int unsigned GAP_CYCLES = 12,
   localparam int unsigned IW         = idx_w(N_SRC)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_SRC-1:0]   s_tvalid,
   input  logic [8*N_SRC-1:0] s_tdata,
   output logic [N_SRC-1:0]   s_tready,
   output logic               m_tvalid,
   output logic [7:0]         m_tdata,
   output logic               m_tlast,
   input  logic               m_tready,
   output logic [IW-1:0]      grant_id,
   output logic               busy,
   output logic               len_err
);

   localparam int unsigned GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam state_t      POST_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

   state_t           state, state_nxt;
   logic [IW-1:0]    rr_ptr, rr_nxt, grant_nxt, pick_idx;
   logic             pick_any;
   logic [7:0]       len_hi, len_hi_nxt;
   logic [LEN_W-1:0] remaining, rem_nxt, len_cur;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic             len_err_nxt;
   logic             src_valid, xfer, fwd, frame_done, rem_last;
   logic [7:0]       src_byte;

   rr_pick #(.N_SRC(N_SRC)) u_pick (
      .req     (s_tvalid),
      .ptr     (rr_ptr),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         grant_id  <= '0;
         rr_ptr    <= '0;
         len_hi    <= '0;
         remaining <= '0;
         gap_cnt   <= '0;
         len_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant_id  <= grant_nxt;
         rr_ptr    <= rr_nxt;
         len_hi    <= len_hi_nxt;
         remaining <= rem_nxt;
         gap_cnt   <= gap_nxt;
         len_err   <= len_err_nxt;
      end
   end

   // Next-state logic and the zero-latency pass-through of the granted source.
   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant_id;
      rr_nxt      = rr_ptr;
      len_hi_nxt  = len_hi;
      rem_nxt     = remaining;
      gap_nxt     = gap_cnt;
      len_err_nxt = 1'b0;
      frame_done  = 1'b0;
      m_tvalid    = 1'b0;
      m_tdata     = '0;
      m_tlast     = 1'b0;
      s_tready    = '0;

      src_valid = s_tvalid[grant_id];
      src_byte  = s_tdata[{grant_id, 3'b000} +: 8];
      xfer      = src_valid & m_tready;
      len_cur   = {len_hi, src_byte};
      rem_last  = (remaining == LEN_W'(1));
      fwd       = (state == HDR_HI) || (state == HDR_LO) || (state == PAYLOAD);

      if (fwd) begin
         m_tvalid           = src_valid;
         m_tdata            = src_byte;
         s_tready[grant_id] = m_tready;
      end

      case (state)
         IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_idx;
               state_nxt = HDR_HI;
            end
         end
         HDR_HI: begin
            if (xfer) begin
               len_hi_nxt = src_byte;
               state_nxt  = HDR_LO;
            end
         end
         HDR_LO: begin
            if (len_cur == '0) begin
               m_tlast    = src_valid;
               frame_done = xfer;
            end else if (32'(len_cur) > MAX_LEN) begin
               m_tlast = src_valid;
               if (xfer) begin
                  len_err_nxt = 1'b1;
                  rem_nxt     = len_cur;
                  state_nxt   = DROP;
               end
            end else if (xfer) begin
               rem_nxt   = len_cur;
               state_nxt = PAYLOAD;
            end
         end
         PAYLOAD: begin
            m_tlast = src_valid & rem_last;
            if (xfer) begin
               rem_nxt    = remaining - LEN_W'(1);
               frame_done = rem_last;
            end
         end
         DROP: begin
            s_tready[grant_id] = 1'b1;
            if (src_valid) begin
               rem_nxt    = remaining - LEN_W'(1);
               frame_done = rem_last;
            end
         end
         GAP: begin
            if (gap_cnt <= GAP_W'(1)) state_nxt = IDLE;
            else                      gap_nxt   = gap_cnt - GAP_W'(1);
         end
         default: state_nxt = IDLE;
      endcase

      if (frame_done) begin
         state_nxt = POST_FRAME;
         gap_nxt   = GAP_W'(GAP_CYCLES);
         rr_nxt    = (grant_id == IW'(N_SRC - 1)) ? '0 : grant_id + IW'(1);
      end

      busy = reset_n && (state != IDLE);
      if (!reset_n) begin
         m_tvalid = 1'b0;
         m_tlast  = 1'b0;
         s_tready = '0;
      end
   end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Randomized self-checking bench for tx_frame_arbiter against a frame-level model.
module tb_tx_frame_arbiter;
   import tx_arb_pkg::*;

   localparam int unsigned N    = 2;
   localparam int unsigned MAXL = 1500;
   localparam int unsigned GAPC = 12;
   localparam int unsigned IW   = idx_w(N);

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   s_tvalid;
   logic [8*N-1:0] s_tdata;
   logic [N-1:0]   s_tready;
   logic           m_tvalid;
   logic [7:0]     m_tdata;
   logic           m_tlast;
   logic           m_tready;
   logic [IW-1:0]  grant_id;
   logic           busy;
   logic           len_err;

   tx_frame_arbiter #(.N_SRC(N), .MAX_LEN(MAXL), .GAP_CYCLES(GAPC)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .s_tvalid (s_tvalid),
      .s_tdata  (s_tdata),
      .s_tready (s_tready),
      .m_tvalid (m_tvalid),
      .m_tdata  (m_tdata),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .grant_id (grant_id),
      .busy     (busy),
      .len_err  (len_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       last;
      logic       ovs;
      logic [7:0] src;
   } exp_t;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] src_q[N][$];     // bytes each source still has to offer
   int         src_flen[N][$];  // total bytes (header + payload) of each queued frame
   int         src_pos[N];      // index within the current frame
   exp_t       exp_src[N][$];   // expected MAC bytes, per source
   int         exp_flen[N][$];  // expected MAC byte count per frame, per source
   exp_t       exp_q[$];        // expected MAC byte stream in arbitration order
   logic [7:0] pay_buf[$];
   int         mdl_ptr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic fill_str(input string s);
      for (int k = 0; k < s.len(); k++) pay_buf.push_back(s[k]);
   endtask

   task automatic fill_rand(input int n);
      for (int k = 0; k < n; k++) pay_buf.push_back(8'($urandom));
   endtask

   // Queue a frame on source s; pay_buf supplies the payload.
   task automatic add_frame(input int s, input int len);
      logic [15:0] l16;
      logic        ovs;
      exp_t        e;
      l16 = 16'(len);
      ovs = (len > int'(MAXL));
      src_q[s].push_back(l16[15:8]);
      src_q[s].push_back(l16[7:0]);
      foreach (pay_buf[k]) src_q[s].push_back(pay_buf[k]);
      src_flen[s].push_back(2 + len);
      e.src = 8'(s);
      e.d = l16[15:8]; e.last = 1'b0; e.ovs = 1'b0;
      exp_src[s].push_back(e);
      e.d = l16[7:0]; e.last = (len == 0) || ovs; e.ovs = ovs;
      exp_src[s].push_back(e);
      if (!ovs) begin
         foreach (pay_buf[k]) begin
            e.d = pay_buf[k]; e.last = (k == len - 1); e.ovs = 1'b0;
            exp_src[s].push_back(e);
         end
      end
      exp_flen[s].push_back(ovs ? 2 : 2 + len);
      pay_buf.delete();
   endtask

   // Whole frames are served in round-robin order among sources that still hold frames.
   task automatic build_expected();
      bit found;
      int n;
      do begin
         found = 0;
         for (int k = 0; k < int'(N); k++) begin
            int s;
            s = (mdl_ptr + k) % int'(N);
            if (!found && exp_flen[s].size() > 0) begin
               found = 1;
               n = exp_flen[s].pop_front();
               repeat (n) exp_q.push_back(exp_src[s].pop_front());
               mdl_ptr = (s + 1) % int'(N);
            end
         end
      end while (found);
   endtask

   task automatic clear_all();
      for (int i = 0; i < int'(N); i++) begin
         src_q[i].delete(); src_flen[i].delete(); exp_src[i].delete(); exp_flen[i].delete();
         src_pos[i] = 0;
      end
      exp_q.delete();
      mdl_ptr = 0;
   endtask

   // Drive sources and sink, check every MAC byte; stop when drained or after stop_bytes bytes.
   task automatic run(input string name, input int budget, input bit stall, input int stop_bytes);
      int cyc = 0, n_out = 0, quiet = 0, gap_busy = -1;
      bit exp_lerr = 0, track = 0, empty;
      exp_t e;
      while (cyc < budget) begin
         @(posedge clk); #1;
         m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int i = 0; i < int'(N); i++) begin
            if (src_q[i].size() > 0) begin
               s_tvalid[i]      = (src_pos[i] == 0 || !stall) ? 1'b1 : 1'($urandom_range(0, 1));
               s_tdata[8*i +: 8] = src_q[i][0];
            end else begin
               s_tvalid[i]      = 1'b0;
               s_tdata[8*i +: 8] = 8'h00;
            end
         end
         #1;
         chk({name, ".len_err"}, 32'(len_err), 32'(exp_lerr));
         exp_lerr = 1'b0;
         if (m_tlast && !m_tvalid) chk({name, ".tlast_wo_valid"}, 32'(m_tlast), 32'(0));
         chk({name, ".tready_onehot"}, 32'($countones(s_tready) <= 1), 32'(1));
         if (gap_busy >= 0) begin
            if (busy) gap_busy++;
            else begin
               chk({name, ".gap_len"}, 32'(gap_busy), 32'(GAPC));
               gap_busy = -1;
            end
         end
         if (m_tvalid && track) begin
            chk({name, ".ifg"}, 32'(quiet >= int'(GAPC) + 1), 32'(1));
            track = 0;
         end else if (!m_tvalid) quiet++;
         if (m_tvalid && m_tready) begin
            n_out++;
            chk({name, ".busy"}, 32'(busy), 32'(1));
            if (exp_q.size() == 0) chk({name, ".extra_byte"}, 32'(m_tdata), 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk({name, ".data"},  32'(m_tdata),  32'(e.d));
               chk({name, ".last"},  32'(m_tlast),  32'(e.last));
               chk({name, ".grant"}, 32'(grant_id), 32'(e.src));
               if (e.last) begin
                  exp_lerr = e.ovs;
                  track    = 1; quiet = 0;
                  if (!e.ovs) gap_busy = 0;
               end
            end
         end
         for (int i = 0; i < int'(N); i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
               void'(src_q[i].pop_front());
               src_pos[i]++;
               if (src_pos[i] == src_flen[i][0]) begin
                  void'(src_flen[i].pop_front());
                  src_pos[i] = 0;
               end
            end
         end
         cyc++;
         if (stop_bytes > 0 && n_out >= stop_bytes) return;
         empty = (exp_q.size() == 0);
         for (int i = 0; i < int'(N); i++) if (src_q[i].size() > 0) empty = 0;
         if (empty && !busy && gap_busy < 0) break;
      end
      chk({name, ".timeout"}, 32'(cyc < budget), 32'(1));
      chk({name, ".drained"}, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      s_tvalid = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
      reset_n  = 1'b0;
      clear_all();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.m_tvalid", 32'(m_tvalid), 32'(0));
      chk("rst.s_tready", 32'(s_tready), 32'(0));
      chk("rst.busy",     32'(busy),     32'(0));
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst.m_tvalid", 32'(m_tvalid), 32'(0));
      chk("post_rst.grant",    32'(grant_id), 32'(0));
      chk("post_rst.len_err",  32'(len_err),  32'(0));
      chk("post_rst.busy",     32'(busy),     32'(0));

      // Single frame carrying "HELLO WORLD".
      fill_str("HELLO WORLD");
      add_frame(0, 11);
      build_expected();
      run("hello", 200, 0, 0);

      // Two sources, two short frames each: frames must alternate.
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < int'(N); s++) begin
            fill_rand(3);
            add_frame(s, 3);
         end
      end
      build_expected();
      run("rr", 400, 0, 0);

      // Random valid/ready stalls on an L=5 frame plus random-length traffic.
      fill_rand(5);
      add_frame(0, 5);
      for (int f = 0; f < 8; f++) begin
         int l;
         l = int'($urandom_range(0, 30));
         fill_rand(l);
         add_frame(int'($urandom_range(0, N - 1)), l);
      end
      build_expected();
      run("stall", 4000, 1, 0);

      // Empty frame, then a normal one.
      add_frame(1, 0);
      fill_rand(4);
      add_frame(0, 4);
      build_expected();
      run("zero_len", 400, 0, 0);

      // Oversize frame is drained; later frames are unaffected.
      fill_rand(1600);
      add_frame(0, 1600);
      fill_rand(6);
      add_frame(1, 6);
      fill_rand(2);
      add_frame(0, 2);
      build_expected();
      run("oversize", 3000, 0, 0);

      // Reset in the middle of a payload abandons the frame.
      fill_rand(20);
      add_frame(0, 20);
      fill_rand(3);
      add_frame(1, 3);
      build_expected();
      run("pre_rst", 200, 0, 7);
      reset_n = 1'b0;
      #1;
      chk("mid_rst.m_tvalid", 32'(m_tvalid), 32'(0));
      chk("mid_rst.s_tready", 32'(s_tready), 32'(0));
      @(posedge clk); #1;
      reset_n = 1'b1;
      #1;
      chk("after_rst.m_tvalid", 32'(m_tvalid), 32'(0));
      chk("after_rst.m_tlast",  32'(m_tlast),  32'(0));
      chk("after_rst.s_tready", 32'(s_tready), 32'(0));
      chk("after_rst.busy",     32'(busy),     32'(0));
      clear_all();
      fill_rand(4);
      add_frame(1, 4);
      fill_rand(20);
      add_frame(0, 20);
      build_expected();
      run("regrant", 400, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
